decode_stage: RTL and testbench

- Registered instruction-decode stage sitting directly upstream of the 8x8-bit register file. Consumes 9-bit instructions from fetch; produces the register file's control/address inputs (readRegister1, readRegister2, immediate, regWrite, ltValue) plus ALU opcode.
- Valid/ready handshake on both sides, per-register write scoreboard for RAW interlock, flush, and a HALT state.

---
 rtl/decode_stage_if.sv | 39 +++
 rtl/decode_stage.sv | 195 +++++++++++++++++++
 tb/tb_decode_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
// Groups the fetch-side handshake (instr/inValid/inReady) and the decoded
// output bus toward the register file / ALU (outValid/outReady plus fields).
//   modport slave  : the decode stage itself
//   modport master : the surrounding pipeline (fetch + downstream consumer)
// Signals:
//   instr[8:0]       fetch -> decode, [8:6] opcode, [5:3] ra, [2:0] rb/index
//   inValid/inReady  fetch-side handshake
//   outValid/outReady downstream handshake
//   readRegister1/2, immediate, regWrite, ltValue, aluOp : decoded op
// -----------------------------------------------------------------------------
interface decode_stage_if #(
   parameter int LT_WIDTH = 8
);
   logic [8:0]          instr;
   logic                inValid;
   logic                inReady;
   logic                outReady;
   logic                outValid;
   logic [2:0]          readRegister1;
   logic [2:0]          readRegister2;
   logic                immediate;
   logic                regWrite;
   logic [LT_WIDTH-1:0] ltValue;
   logic [2:0]          aluOp;

   modport slave (
      input  instr, inValid, outReady,
      output inReady, outValid, readRegister1, readRegister2,
             immediate, regWrite, ltValue, aluOp
   );

   modport master (
      output instr, inValid, outReady,
      input  inReady, outValid, readRegister1, readRegister2,
             immediate, regWrite, ltValue, aluOp
   );
endinterface

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Registered instruction decode in front of the 8x8 register file. Decodes a
// 9-bit instruction into register addresses, immediate select, write enable,
// literal value and ALU opcode; interlocks on RAW hazards via a per-register
// busy scoreboard; supports flush and a terminal HALTED state.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   bus           decode_stage_if.slave (fetch handshake + decoded output)
//   wbValid/wbReg writeback completion, clears the scoreboard bit
//   flush         kills the output op and clears the scoreboard
//   halted        high once a HALT has been accepted
//   stallCount    stall-cycle counter, present only when DECODE_STATS_EN is
//                 defined; constant 0 otherwise
// -----------------------------------------------------------------------------
module decode_stage #(
   parameter int LT_WIDTH = 8,
   parameter int NUM_REGS = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   decode_stage_if.slave        bus,
   input  logic                 wbValid,
   input  logic [2:0]           wbReg,
   input  logic                 flush,
   output logic                 halted,
   output logic [15:0]          stallCount
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_ADDI = 3'b100;
   localparam logic [2:0] OP_LDI  = 3'b101;
   localparam logic [2:0] OP_BNZ  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   function automatic logic [7:0] lit_lut(input logic [2:0] idx);
      case (idx)
         3'd0:    lit_lut = 8'h01;
         3'd1:    lit_lut = 8'h02;
         3'd2:    lit_lut = 8'h04;
         3'd3:    lit_lut = 8'h08;
         3'd4:    lit_lut = 8'h10;
         3'd5:    lit_lut = 8'h7F;
         3'd6:    lit_lut = 8'h80;
         default: lit_lut = 8'hFF;
      endcase
   endfunction

   state_t               state_q;
   logic                 halted_q;
   logic                 out_valid_q;
   logic [2:0]           rr1_q, rr2_q, alu_op_q;
   logic                 imm_q, reg_write_q;
   logic [LT_WIDTH-1:0]  lt_q;
   logic [NUM_REGS-1:0]  sb_q, sb_d;

   logic [2:0]           opcode, ra, rb;
   logic                 uses_ra, uses_rb, dec_imm, dec_rw;
   logic                 hazard, in_ready, accept, is_halt;

   assign opcode  = bus.instr[8:6];
   assign ra      = bus.instr[5:3];
   assign rb      = bus.instr[2:0];
   assign is_halt = (opcode == OP_HALT);

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      uses_ra = 1'b0;
      uses_rb = 1'b0;
      dec_imm = 1'b0;
      dec_rw  = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
            uses_ra = 1'b1;
            uses_rb = 1'b1;
            dec_rw  = 1'b1;
         end
         OP_ADDI: begin
            uses_ra = 1'b1;
            dec_imm = 1'b1;
            dec_rw  = 1'b1;
         end
         OP_LDI: begin
            dec_imm = 1'b1;
            dec_rw  = 1'b1;
         end
         OP_BNZ:  uses_ra = 1'b1;
         default: ;
      endcase
   end

   // Only source operands interlock; a busy destination (WAW) is allowed.
   // The scoreboard is consulted as registered, so a writeback releases the
   // dependent instruction on the following cycle.
   assign hazard   = (uses_ra && sb_q[ra]) || (uses_rb && sb_q[rb]);
   assign in_ready = (state_q == ST_RUN) && !hazard && !flush &&
                     (!out_valid_q || bus.outReady);
   assign accept   = bus.inValid && in_ready;

   // Clear from writeback first, then set from a new accept, so a same-cycle
   // set and clear of one register leaves it busy. Flush overrides both.
   always_comb begin
      sb_d = sb_q;
      if (wbValid)
         sb_d[wbReg] = 1'b0;
      if (accept && dec_rw)
         sb_d[ra] = 1'b1;
      if (flush)
         sb_d = '0;
   end

   // NOTE: reset is synchronous, so it is sampled only on the clock edge and
   // lives inside the clocked block rather than in its sensitivity list.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_RUN;
         halted_q    <= 1'b0;
         out_valid_q <= 1'b0;
         rr1_q       <= '0;
         rr2_q       <= '0;
         alu_op_q    <= '0;
         imm_q       <= 1'b0;
         reg_write_q <= 1'b0;
         lt_q        <= '0;
         sb_q        <= '0;
      end else begin
         sb_q <= sb_d;

         if (flush) begin
            out_valid_q <= 1'b0;
         end else if (accept && !is_halt) begin
            out_valid_q <= 1'b1;
            rr1_q       <= ra;
            rr2_q       <= uses_rb ? rb : 3'd0;
            alu_op_q    <= opcode;
            imm_q       <= dec_imm;
            reg_write_q <= dec_rw;
            lt_q        <= LT_WIDTH'(lit_lut(rb));
         end else if (bus.outReady) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            ST_RUN: begin
               if (accept && is_halt) begin
                  state_q  <= ST_HALTED;
                  halted_q <= 1'b1;
               end
            end
            ST_HALTED: ;  // only reset leaves this state
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign bus.inReady       = in_ready;
   assign bus.outValid      = out_valid_q;
   assign bus.readRegister1 = rr1_q;
   assign bus.readRegister2 = rr2_q;
   assign bus.immediate     = imm_q;
   assign bus.regWrite      = reg_write_q;
   assign bus.ltValue       = lt_q;
   assign bus.aluOp         = alu_op_q;
   assign halted            = halted_q;

`ifdef DECODE_STATS_EN
   logic [15:0] stall_cnt_q;

   // Counts RUN cycles where fetch offers an instruction that is refused;
   // saturates rather than wrapping.
   always_ff @(posedge clock) begin
      if (reset)
         stall_cnt_q <= '0;
      else if ((state_q == ST_RUN) && bus.inValid && !in_ready &&
               (stall_cnt_q != 16'hFFFF))
         stall_cnt_q <= stall_cnt_q + 16'd1;
   end

   assign stallCount = stall_cnt_q;
`else
   assign stallCount = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Directed bench for decode_stage. Accepted instructions push their expected
// decode onto a queue; a monitor pops and compares each op as it retires.
// -----------------------------------------------------------------------------
module tb_decode_stage;

   typedef struct packed {
      logic [2:0] rr1;
      logic [2:0] rr2;
      logic       imm;
      logic       rw;
      logic [7:0] lt;
      logic [2:0] op;
   } exp_t;

`ifdef DECODE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic        wbValid;
   logic [2:0]  wbReg;
   logic        flush;
   logic        halted;
   logic [15:0] stallCount;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   decode_stage_if #(.LT_WIDTH(8)) bus ();

   decode_stage #(.LT_WIDTH(8), .NUM_REGS(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus.slave),
      .wbValid    (wbValid),
      .wbReg      (wbReg),
      .flush      (flush),
      .halted     (halted),
      .stallCount (stallCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference decode straight from the opcode table.
   function automatic exp_t model(input logic [8:0] ins);
      logic [7:0] lut [8];
      exp_t e;
      lut = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h7F, 8'h80, 8'hFF};
      e.rr1 = ins[5:3];
      e.op  = ins[8:6];
      e.lt  = lut[ins[2:0]];
      e.rr2 = 3'd0;
      e.imm = 1'b0;
      e.rw  = 1'b0;
      case (ins[8:6])
         3'd0, 3'd1, 3'd2, 3'd3: begin e.rr2 = ins[2:0]; e.rw = 1'b1; end
         3'd4, 3'd5:             begin e.imm = 1'b1;     e.rw = 1'b1; end
         default: ;
      endcase
      return e;
   endfunction

   // Retirement monitor: one expected op per outValid && outReady cycle.
   always @(negedge clock) begin
      if (!reset && !flush && bus.outValid && bus.outReady) begin
         if (exp_q.size() == 0) begin
            check("unexpected_op", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_rr1", 32'(bus.readRegister1), 32'(e.rr1));
            check("out_rr2", 32'(bus.readRegister2), 32'(e.rr2));
            check("out_imm", 32'(bus.immediate),     32'(e.imm));
            check("out_rw",  32'(bus.regWrite),      32'(e.rw));
            check("out_lt",  32'(bus.ltValue),       32'(e.lt));
            check("out_op",  32'(bus.aluOp),         32'(e.op));
         end
      end
   end

   // Present an instruction, wait (bounded) for inReady, record the expectation.
   task automatic send(input logic [8:0] ins, input string tag, input int budget);
      int k;
      k = 0;
      @(posedge clock); #1;
      bus.instr   = ins;
      bus.inValid = 1'b1;
      @(negedge clock);
      while (!bus.inReady && k < budget) begin
         @(negedge clock);
         k++;
      end
      check({tag, "_accept"}, 32'(bus.inReady), 32'd1);
      if (bus.inReady && ins[8:6] != 3'b111)
         exp_q.push_back(model(ins));
      @(posedge clock); #1;
      bus.inValid = 1'b0;
   endtask

   initial begin
      logic [15:0] sc0;
      reset        = 1'b1;
      wbValid      = 1'b0;
      wbReg        = '0;
      flush        = 1'b0;
      bus.instr    = '0;
      bus.inValid  = 1'b0;
      bus.outReady = 1'b1;

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_outValid", 32'(bus.outValid), 32'd0);
      check("rst_halted",   32'(halted), 32'd0);
      check("rst_fields",   {bus.readRegister1, bus.readRegister2, bus.immediate,
                             bus.regWrite, bus.ltValue, bus.aluOp}, 32'd0);
      check("rst_stall",    32'(stallCount), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("rst_inReady", 32'(bus.inReady), 32'd1);

      // ADD r1,r2 then LDI r3,#6 (one-cycle latency)
      send(9'h00A, "add_r1_r2", 0);
      check("add_outValid", 32'(bus.outValid), 32'd1);
      send(9'h15E, "ldi_r3_6", 0);
      check("ldi_outValid", 32'(bus.outValid), 32'd1);

      // RAW: SUB r4,r1 stalls on busy r1 until writeback
      @(posedge clock); #1;
      bus.instr   = 9'h061;
      bus.inValid = 1'b1;
      @(negedge clock);
      sc0 = stallCount;
      check("raw_stall0", 32'(bus.inReady), 32'd0);
      repeat (3) begin
         @(negedge clock);
         check("raw_stall", 32'(bus.inReady), 32'd0);
      end
      check("raw_stallCount", 32'(stallCount - sc0), STATS ? 32'd3 : 32'd0);
      @(posedge clock); #1;
      wbValid = 1'b1;
      wbReg   = 3'd1;
      @(negedge clock);
      check("raw_wb_cycle", 32'(bus.inReady), 32'd0);
      @(posedge clock); #1;
      wbValid = 1'b0;
      @(negedge clock);
      check("raw_released", 32'(bus.inReady), 32'd1);
      if (bus.inReady) exp_q.push_back(model(9'h061));
      @(posedge clock); #1;
      bus.inValid = 1'b0;

      // Backpressure: SUB held while AND r5,r6 is offered
      bus.outReady = 1'b0;
      @(posedge clock); #1;
      bus.instr   = 9'h0AE;
      bus.inValid = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("bp_inReady",  32'(bus.inReady), 32'd0);
         check("bp_outValid", 32'(bus.outValid), 32'd1);
         check("bp_hold",     {bus.readRegister1, bus.readRegister2, bus.aluOp},
                              {23'd0, 3'd4, 3'd1, 3'd1});
      end
      @(posedge clock); #1;
      bus.outReady = 1'b1;
      @(negedge clock);
      check("bp_release", 32'(bus.inReady), 32'd1);
      if (bus.inReady) exp_q.push_back(model(9'h0AE));
      @(posedge clock); #1;
      bus.inValid = 1'b0;

      // Flush: ADDI r1 held with r1,r3 busy; flush kills it and clears busy bits
      send(9'h108, "addi_r1", 0);
      bus.outReady = 1'b0;
      flush        = 1'b1;
      @(negedge clock);
      check("flush_inReady",  32'(bus.inReady), 32'd0);
      check("flush_outValid", 32'(bus.outValid), 32'd1);
      @(posedge clock); #1;
      flush = 1'b0;
      exp_q.delete();
      @(negedge clock);
      check("flush_killed", 32'(bus.outValid), 32'd0);
      check("flush_halted", 32'(halted), 32'd0);
      bus.outReady = 1'b1;
      send(9'h0D1, "xor_r2_r1_after_flush", 0);

      // BNZ, WAW LDI onto busy r2, ADDI literal index 5
      send(9'h1B0, "bnz_r6", 0);
      send(9'h157, "ldi_waw_r2", 0);
      send(9'h105, "addi_r0_5", 0);

      // HALT: accepted, then refuses everything
      send(9'h1C0, "halt", 0);
      bus.instr   = 9'h00A;
      bus.inValid = 1'b1;
      @(negedge clock);
      sc0 = stallCount;
      check("halt_halted",   32'(halted), 32'd1);
      check("halt_outValid", 32'(bus.outValid), 32'd0);
      repeat (20) begin
         @(negedge clock);
         check("halt_inReady", 32'(bus.inReady), 32'd0);
      end
      check("halt_no_stall_count", 32'(stallCount), 32'(sc0));
      check("halt_queue_empty", 32'(exp_q.size()), 32'd0);

      // Synchronous reset leaves HALTED
      @(posedge clock); #1;
      bus.inValid = 1'b0;
      reset       = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("rst2_halted",   32'(halted), 32'd0);
      check("rst2_inReady",  32'(bus.inReady), 32'd1);
      check("rst2_outValid", 32'(bus.outValid), 32'd0);
      check("rst2_stall",    32'(stallCount), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
